// File: rtl/ex_multicycle_sched_pkg.sv
// Shared definitions for the EX-stage multi-cycle scheduler.
//   sched_state_e : scheduler FSM states (idle, ROM load, counting, completion)
//   op_class_e    : op class codes, also the latency ROM select code
package ex_multicycle_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StDone = 2'b11
    } sched_state_e;

    // Class 3 has no latency ROM entry (zero cycles) and completes with an error.
    typedef enum logic [1:0] {
        ClsShort   = 2'b00,
        ClsMid     = 2'b01,
        ClsLong    = 2'b10,
        ClsIllegal = 2'b11
    } op_class_e;

endpackage

// File: rtl/ex_multicycle_sched_arb.sv
// Two-way round-robin arbiter.
//   valid[1:0] : request lines
//   ptr        : requester that wins when both are valid
//   grant[1:0] : one-hot grant (all zero when nothing is valid)
module ex_multicycle_sched_arb (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] && (!valid[1] || !ptr);
        grant[1] = valid[1] && (!valid[0] ||  ptr);
    end

endmodule

// File: rtl/ex_multicycle_sched.sv
// EX-stage scheduler for the shared multi-cycle functional unit.
// Arbitrates two requesters round-robin, looks up the op latency in an external
// ROM, counts the unit's busy cycles, stalls EX meanwhile and returns a tagged
// completion pulse.
//   CLK, RSTN              : clock, synchronous active-low reset
//   REQx_VALID/CLASS/TAG   : requester x op, REQx_READY is the combinational grant
//   FLUSH                  : abort whatever is in flight, no grant this cycle
//   ROM_SELECT / ROM_OP    : latency ROM lookup (select = latched class)
//   UNIT_START             : one-cycle start pulse to the multi-cycle unit
//   STALL                  : high while an op is in flight
//   DONE_VALID/REQ/TAG/ERR : completion pulse, qualifiers zero when not valid
module ex_multicycle_sched
    import ex_multicycle_sched_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             REQ0_VALID,
    input  logic [1:0]       REQ0_CLASS,
    input  logic [TAG_W-1:0] REQ0_TAG,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [1:0]       REQ1_CLASS,
    input  logic [TAG_W-1:0] REQ1_TAG,
    output logic             REQ1_READY,
    input  logic             FLUSH,
    output logic [1:0]       ROM_SELECT,
    input  logic [31:0]      ROM_OP,
    output logic             UNIT_START,
    output logic             STALL,
    output logic             DONE_VALID,
    output logic             DONE_REQ,
    output logic [TAG_W-1:0] DONE_TAG,
    output logic             DONE_ERR
);

    localparam logic [CNT_W-1:0] CntOne = 1;

    sched_state_e     state_q, state_d;
    logic             ptr_q, ptr_d;
    op_class_e        cls_q, cls_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             req_q, req_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       grant;
    logic             rdy0, rdy1;
    logic             unit_start;
    logic             done_valid;
    logic [CNT_W-1:0] rom_lat;

    // ROM entries never exceed the counter range; the upper OP bits are don't-care.
    logic unused_rom_hi;
    assign unused_rom_hi = ^ROM_OP[31:CNT_W];
    assign rom_lat       = ROM_OP[CNT_W-1:0];

    ex_multicycle_sched_arb u_arb (
        .valid ({REQ1_VALID, REQ0_VALID}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cls_d      = cls_q;
        tag_d      = tag_q;
        req_d      = req_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        rdy0       = 1'b0;
        rdy1       = 1'b0;
        unit_start = 1'b0;
        done_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!FLUSH) begin
                    rdy0 = grant[0];
                    rdy1 = grant[1];
                    if (grant != 2'b00) begin
                        cls_d   = op_class_e'(grant[1] ? REQ1_CLASS : REQ0_CLASS);
                        tag_d   = grant[1] ? REQ1_TAG : REQ0_TAG;
                        req_d   = grant[1];
                        err_d   = 1'b0;
                        // Next time both ask, the other requester wins.
                        ptr_d   = ~grant[1];
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                cnt_d = rom_lat;
                if (rom_lat != '0) begin
                    unit_start = 1'b1;
                    state_d    = StRun;
                end else begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything; the arbitration pointer is left alone.
        if (FLUSH) begin
            state_d    = StIdle;
            cnt_d      = '0;
            unit_start = 1'b0;
            done_valid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            cls_q   <= ClsShort;
            tag_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cls_q   <= cls_d;
            tag_q   <= tag_d;
            req_q   <= req_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is forced low while reset is asserted.
    assign REQ0_READY = RSTN && rdy0;
    assign REQ1_READY = RSTN && rdy1;
    assign ROM_SELECT = RSTN ? cls_q : 2'b00;
    assign UNIT_START = RSTN && unit_start;
    assign STALL      = RSTN && (state_q != StIdle);
    assign DONE_VALID = RSTN && done_valid;
    assign DONE_REQ   = DONE_VALID && req_q;
    assign DONE_TAG   = DONE_VALID ? tag_q : '0;
    assign DONE_ERR   = DONE_VALID && err_q;

endmodule

// File: tb/tb_ex_multicycle_sched.sv
// Self-checking bench for ex_multicycle_sched: a cycle-indexed model (handshake
// cycle + class latency) predicts every output each cycle, plus directed
// scenarios with hand-computed latencies, grant order and flush/reset effects.
module tb_ex_multicycle_sched;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       REQ0_VALID = 1'b0;
    logic [1:0] REQ0_CLASS = 2'b00;
    logic [3:0] REQ0_TAG = 4'h0;
    logic       REQ0_READY;
    logic       REQ1_VALID = 1'b0;
    logic [1:0] REQ1_CLASS = 2'b00;
    logic [3:0] REQ1_TAG = 4'h0;
    logic       REQ1_READY;
    logic       FLUSH = 1'b0;
    logic [1:0] ROM_SELECT;
    logic [31:0] ROM_OP;
    logic       UNIT_START;
    logic       STALL;
    logic       DONE_VALID;
    logic       DONE_REQ;
    logic [3:0] DONE_TAG;
    logic       DONE_ERR;

    int total = 0;
    int bad = 0;

    ex_multicycle_sched #(.TAG_W(4), .CNT_W(8)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_CLASS (REQ0_CLASS),
        .REQ0_TAG   (REQ0_TAG),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_CLASS (REQ1_CLASS),
        .REQ1_TAG   (REQ1_TAG),
        .REQ1_READY (REQ1_READY),
        .FLUSH      (FLUSH),
        .ROM_SELECT (ROM_SELECT),
        .ROM_OP     (ROM_OP),
        .UNIT_START (UNIT_START),
        .STALL      (STALL),
        .DONE_VALID (DONE_VALID),
        .DONE_REQ   (DONE_REQ),
        .DONE_TAG   (DONE_TAG),
        .DONE_ERR   (DONE_ERR)
    );

    always #5 CLK = ~CLK;

    // Latency ROM: garbage in the upper bits must be ignored by the DUT.
    function automatic logic [7:0] lat_of(input logic [1:0] c);
        case (c)
            2'd0:    return 8'd12;
            2'd1:    return 8'd20;
            2'd2:    return 8'd27;
            default: return 8'd0;
        endcase
    endfunction

    logic [23:0] rom_junk = 24'hA5_5A_C3;
    assign ROM_OP = {rom_junk, lat_of(ROM_SELECT)};

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an op handshaken in cycle h with latency n occupies the
    // unit for cycles h+1 .. h+2+n; start at h+1 if n>0, completion at h+2+n.
    int         cyc = 0;
    bit         m_active = 0;
    int         m_hs = 0;
    int         m_n = 0;
    logic [1:0] m_cls = 2'b00;
    logic [3:0] m_tag = 4'h0;
    bit         m_req = 0;
    bit         m_ptr = 0;

    logic m_can, m_g0, m_g1;
    int   m_k;
    logic e_start, e_done, e_stall;
    logic [1:0] e_sel;

    assign m_can   = RSTN && !FLUSH && !m_active;
    assign m_g0    = m_can && REQ0_VALID && (!REQ1_VALID || !m_ptr);
    assign m_g1    = m_can && REQ1_VALID && (!REQ0_VALID || m_ptr);
    assign m_k     = cyc - m_hs;
    assign e_stall = RSTN && m_active;
    assign e_start = e_stall && !FLUSH && m_k == 1 && m_n != 0;
    assign e_done  = e_stall && !FLUSH && m_k == 2 + m_n;
    assign e_sel   = RSTN ? m_cls : 2'b00;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RSTN) begin
            m_active <= 0;
            m_ptr    <= 0;
            m_cls    <= 2'b00;
            m_tag    <= 4'h0;
            m_req    <= 0;
            m_n      <= 0;
        end else if (FLUSH) begin
            m_active <= 0;
        end else if (!m_active) begin
            if (m_g0 || m_g1) begin
                m_active <= 1;
                m_hs     <= cyc;
                m_req    <= m_g1;
                m_cls    <= m_g1 ? REQ1_CLASS : REQ0_CLASS;
                m_tag    <= m_g1 ? REQ1_TAG : REQ0_TAG;
                m_n      <= int'(lat_of(m_g1 ? REQ1_CLASS : REQ0_CLASS));
                m_ptr    <= !m_g1;
            end
        end else if (cyc - m_hs == 2 + m_n) begin
            m_active <= 0;
        end
    end

    always @(negedge CLK) begin
        check("ready0", REQ0_READY, m_g0);
        check("ready1", REQ1_READY, m_g1);
        check("rom_select", ROM_SELECT, e_sel);
        check("unit_start", UNIT_START, e_start);
        check("stall", STALL, e_stall);
        check("done_valid", DONE_VALID, e_done);
        check("done_req", DONE_REQ, e_done ? m_req : 1'b0);
        check("done_tag", DONE_TAG, e_done ? m_tag : 4'h0);
        check("done_err", DONE_ERR, e_done && m_n == 0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
    endtask

    // Single op from one requester; latency and stall span are literal.
    task automatic one_op(input bit r, input logic [1:0] c, input logic [3:0] tg,
                          input int lat, input bit e);
        int  t;
        int  d;
        int  stall_cnt;
        bit  seen;
        if (r) begin
            REQ1_VALID = 1'b1; REQ1_CLASS = c; REQ1_TAG = tg;
        end else begin
            REQ0_VALID = 1'b1; REQ0_CLASS = c; REQ0_TAG = tg;
        end
        @(negedge CLK);
        t = cyc;
        check("dir_ready", r ? REQ1_READY : REQ0_READY, 1);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        seen = 0;
        d = 0;
        stall_cnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (STALL) stall_cnt++;
            if (i == 0) check("dir_start", UNIT_START, e ? 0 : 1);
            if (DONE_VALID) begin
                seen = 1;
                d = cyc;
                check("dir_tag", DONE_TAG, tg);
                check("dir_req", DONE_REQ, r);
                check("dir_err", DONE_ERR, e);
            end
        end
        check("dir_done_seen", seen, 1);
        check("dir_latency", d - t, lat);
        check("dir_stall_span", stall_cnt, lat);
        tick();
    endtask

    int gid[4];
    int gcyc[4];
    int ng;
    int t0;
    int ndone;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        one_op(1'b0, 2'd0, 4'd5, 14, 1'b0);
        one_op(1'b1, 2'd2, 4'd9, 29, 1'b0);
        one_op(1'b0, 2'd3, 4'hA, 2, 1'b1);
        one_op(1'b1, 2'd1, 4'hC, 22, 1'b0);

        // Both requesting continuously: strict alternation from requester 0.
        do_reset();
        REQ0_VALID = 1'b1; REQ0_CLASS = 2'd0; REQ0_TAG = 4'd3;
        REQ1_VALID = 1'b1; REQ1_CLASS = 2'd0; REQ1_TAG = 4'd7;
        for (int i = 0; i < 4; i++) begin
            gid[i] = 9;
            gcyc[i] = 0;
        end
        ng = 0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            @(negedge CLK);
            if (REQ0_READY || REQ1_READY) begin
                gid[ng] = REQ1_READY ? 1 : 0;
                gcyc[ng] = cyc;
                ng++;
            end
            tick();
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        check("alt_grant0", gid[0], 0);
        check("alt_grant1", gid[1], 1);
        check("alt_grant2", gid[2], 0);
        check("alt_grant3", gid[3], 1);
        check("alt_gap1", gcyc[1] - gcyc[0], 15);
        check("alt_gap2", gcyc[2] - gcyc[1], 15);
        check("alt_gap3", gcyc[3] - gcyc[2], 15);
        repeat (20) tick();

        // Flush in RUN at handshake+6: idle next cycle, no completion.
        REQ0_VALID = 1'b1; REQ0_CLASS = 2'd1; REQ0_TAG = 4'd3;
        @(negedge CLK);
        t0 = cyc;
        tick();
        REQ0_VALID = 1'b0;
        repeat (5) tick();
        FLUSH = 1'b1;
        @(negedge CLK);
        check("flush_cycle_offset", cyc - t0, 6);
        check("flush_in_run_stall", STALL, 1);
        tick();
        FLUSH = 1'b0;
        @(negedge CLK);
        check("flush_stall_drop", STALL, 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (DONE_VALID) ndone++;
        end
        check("flush_no_done", ndone, 0);
        tick();

        // Flush in IDLE blocks the grant.
        FLUSH = 1'b1;
        REQ0_VALID = 1'b1; REQ0_CLASS = 2'd0;
        @(negedge CLK);
        check("flush_idle_ready0", REQ0_READY, 0);
        tick();
        FLUSH = 1'b0;
        REQ0_VALID = 1'b0;
        tick();

        // Reset mid-RUN: everything quiet, pointer back to requester 0.
        REQ0_VALID = 1'b1; REQ0_CLASS = 2'd2; REQ0_TAG = 4'd6;
        tick();
        REQ0_VALID = 1'b0;
        repeat (4) tick();
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        @(negedge CLK);
        check("rst_stall", STALL, 0);
        check("rst_rom_select", ROM_SELECT, 0);
        check("rst_done_valid", DONE_VALID, 0);
        check("rst_unit_start", UNIT_START, 0);
        tick();
        REQ0_VALID = 1'b1; REQ0_CLASS = 2'd3;
        REQ1_VALID = 1'b1; REQ1_CLASS = 2'd3;
        @(negedge CLK);
        check("rst_ptr_ready0", REQ0_READY, 1);
        check("rst_ptr_ready1", REQ1_READY, 0);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        repeat (5) tick();

        // Randomised traffic, flushes and resets against the model.
        for (int i = 0; i < 3000; i++) begin
            RSTN       = ($urandom_range(0, 127) != 0);
            FLUSH      = ($urandom_range(0, 31) == 0);
            REQ0_VALID = $urandom_range(0, 1) == 1;
            REQ1_VALID = $urandom_range(0, 1) == 1;
            REQ0_CLASS = 2'($urandom_range(0, 3));
            REQ1_CLASS = 2'($urandom_range(0, 3));
            REQ0_TAG   = 4'($urandom_range(0, 15));
            REQ1_TAG   = 4'($urandom_range(0, 15));
            rom_junk   = 24'($urandom);
            tick();
        end
        RSTN = 1'b1;
        FLUSH = 1'b0;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
